// File: rtl/fifo_write_arbiter_if.sv
// Requester-side valid/ready handshake and FIFO push pins for the write arbiter.
// The master modport is the arbiter; the slave modport is the requesters and FIFO.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          push;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          fifo_full;
  logic                          grant_valid;
  logic [ID_WIDTH-1:0]           grant_id;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, push, wr_data, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, push, wr_data, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ requesters,
// with each grant bounded to MAX_BURST accepted beats.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fifo_write_arbiter_if.master  bus
);
  localparam int ID_WIDTH  = $clog2(NUM_REQ);
  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  grant_id;
  logic [CNT_WIDTH-1:0] beat_cnt;

  logic                  found;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   cand;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [NUM_REQ-1:0]    ready;
  logic                  push_int;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  last_beat;

  // Scan from rr_ptr upward, wrapping modulo NUM_REQ so indices past the
  // last requester are never produced for non-power-of-2 counts.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    ready       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        ready[i]    = (state == BURST) && !bus.fifo_full;
      end
    end
  end

  assign push_int  = (state == BURST) && owner_valid && !bus.fifo_full;
  assign next_ptr  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign last_beat = (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= BURST;
            grant_id <= winner;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (!owner_valid || (push_int && last_beat)) begin
            state    <= IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end else if (push_int) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.push        = push_int;
  assign bus.wr_data     = owner_data;
  assign bus.grant_valid = (state == BURST);
  assign bus.grant_id    = grant_id;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a cycle-level reference model of the arbitration rules.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: current owner (-1 when idle), rotation start, beats taken
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_seq[N];

  // stimulus side bookkeeping, driven by observed handshakes
  int drv_seq[N];
  int remain[N];
  int push_cnt[N];
  logic prev_gv = 1'b0;
  int cur_len = 0;
  int gseq[$];
  int blens[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_edge(input logic [N-1:0] v, input logic full);
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (v[c]) begin
          m_owner = c;
          m_beats = 0;
          break;
        end
      end
    end else if (!v[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (!full) begin
      m_seq[m_owner]++;
      m_beats++;
      if (m_beats == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] vmask, input logic full, output logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      v[i] = vmask[i] && (remain[i] > 0);
      bus.req_data[i*DW +: DW] = {8'(i), 24'(drv_seq[i])};
    end
    bus.req_valid = v;
    bus.fifo_full = full;
  endtask

  task automatic step(input logic [N-1:0] vmask, input logic full);
    logic [N-1:0]  v;
    logic          exp_gv;
    logic          exp_push;
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] exp_data;
    drive(vmask, full, v);
    @(negedge clk);
    exp_gv    = (m_owner >= 0);
    exp_push  = 1'b0;
    exp_ready = '0;
    exp_data  = '0;
    if (exp_gv) begin
      if (!full) exp_ready[m_owner] = 1'b1;
      exp_push = v[m_owner] && !full;
      exp_data = {8'(m_owner), 24'(m_seq[m_owner])};
    end
    check("grant_valid", 64'(bus.grant_valid), 64'(exp_gv));
    check("push", 64'(bus.push), 64'(exp_push));
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (exp_gv) check("grant_id", 64'(bus.grant_id), 64'(m_owner));
    if (exp_push) check("wr_data", 64'(bus.wr_data), 64'(exp_data));
    if (bus.grant_valid && !prev_gv) gseq.push_back(int'(bus.grant_id));
    if (prev_gv && !bus.grant_valid) begin
      blens.push_back(cur_len);
      cur_len = 0;
    end
    if (bus.push) cur_len++;
    prev_gv = bus.grant_valid;
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i] && v[i]) begin
        drv_seq[i]++;
        remain[i]--;
        push_cnt[i]++;
      end
    end
    model_edge(v, full);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    prev_gv = 1'b0;
    cur_len = 0;
    gseq.delete();
    blens.delete();
    for (int i = 0; i < N; i++) remain[i] = 0;
  endtask

  task automatic apply_reset();
    bus.req_valid = '1;
    bus.fifo_full = 1'b0;
    reset_n = 1'b0;
    #2;
    check("rst_push", 64'(bus.push), 64'(0));
    check("rst_ready", 64'(bus.req_ready), 64'(0));
    check("rst_grant_valid", 64'(bus.grant_valid), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base[N];
    int k;
    for (int i = 0; i < N; i++) begin
      m_seq[i] = 0; drv_seq[i] = 0; push_cnt[i] = 0; remain[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    #3;

    // reset with all requesters valid, then first grant goes to 0
    apply_reset();
    for (int i = 0; i < N; i++) remain[i] = 5;
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    check("reset_first_grants", 64'(gseq.size()), 64'(1));
    if (gseq.size() > 0) check("reset_first_id", 64'(gseq[0]), 64'(0));

    // single requester 2 with 10 words: bursts 4,4,2
    apply_reset();
    remain[2] = 10;
    base[2] = push_cnt[2];
    for (int c = 0; c < 30; c++) step(4'b0100, 1'b0);
    check("single_total", 64'(push_cnt[2] - base[2]), 64'(10));
    check("single_bursts", 64'(blens.size()), 64'(3));
    if (blens.size() == 3) begin
      check("single_b0", 64'(blens[0]), 64'(4));
      check("single_b1", 64'(blens[1]), 64'(4));
      check("single_b2", 64'(blens[2]), 64'(2));
    end
    foreach (gseq[j]) check("single_id", 64'(gseq[j]), 64'(2));

    // round-robin with everyone valid
    apply_reset();
    for (int i = 0; i < N; i++) begin
      remain[i] = 1000;
      base[i] = push_cnt[i];
    end
    for (int c = 0; c < 20; c++) step(4'b1111, 1'b0);
    for (int i = 0; i < N; i++) check("rr_count", 64'(push_cnt[i] - base[i]), 64'(MB));
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    check("rr_grants", 64'(gseq.size()), 64'(5));
    if (gseq.size() == 5) begin
      check("rr_g0", 64'(gseq[0]), 64'(0));
      check("rr_g1", 64'(gseq[1]), 64'(1));
      check("rr_g2", 64'(gseq[2]), 64'(2));
      check("rr_g3", 64'(gseq[3]), 64'(3));
      check("rr_g4", 64'(gseq[4]), 64'(0));
    end

    // back-pressure on owner 1 after two beats
    apply_reset();
    remain[1] = 100;
    remain[2] = 100;
    base[1] = push_cnt[1];
    k = 0;
    while ((push_cnt[1] - base[1]) < 2 && k < 10) begin
      step(4'b0010, 1'b0);
      k++;
    end
    check("bp_prefill", 64'(push_cnt[1] - base[1]), 64'(2));
    for (int c = 0; c < 5; c++) step(4'b0110, 1'b1);
    check("bp_held", 64'(push_cnt[1] - base[1]), 64'(2));
    for (int c = 0; c < 4; c++) step(4'b0110, 1'b0);
    check("bp_total", 64'(push_cnt[1] - base[1]), 64'(4));
    check("bp_grants", 64'(gseq.size()), 64'(2));
    if (gseq.size() == 2) begin
      check("bp_g0", 64'(gseq[0]), 64'(1));
      check("bp_g1", 64'(gseq[1]), 64'(2));
    end

    // early release by owner 3, wrap to 0
    apply_reset();
    remain[3] = 100;
    remain[0] = 100;
    base[3] = push_cnt[3];
    k = 0;
    while ((push_cnt[3] - base[3]) < 1 && k < 10) begin
      step(4'b1000, 1'b0);
      k++;
    end
    for (int c = 0; c < 3; c++) step(4'b0001, 1'b0);
    check("er_beats", 64'(push_cnt[3] - base[3]), 64'(1));
    check("er_grants", 64'(gseq.size()), 64'(2));
    if (gseq.size() == 2) begin
      check("er_g0", 64'(gseq[0]), 64'(3));
      check("er_g1", 64'(gseq[1]), 64'(0));
    end
    if (blens.size() > 0) check("er_len", 64'(blens[0]), 64'(1));

    // async reset while owner 3 is pushing, after rr_ptr has moved to 1
    apply_reset();
    remain[0] = 100;
    remain[3] = 100;
    for (int c = 0; c < 6; c++) step(4'b1001, 1'b0);
    begin
      logic [N-1:0] v;
      drive(4'b1001, 1'b0, v);
    end
    #2;
    check("ar_pre_push", 64'(bus.push), 64'(1));
    check("ar_pre_id", 64'(bus.grant_id), 64'(3));
    reset_n = 1'b0;
    #1;
    check("ar_push", 64'(bus.push), 64'(0));
    check("ar_ready", 64'(bus.req_ready), 64'(0));
    check("ar_grant_valid", 64'(bus.grant_valid), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    remain[0] = 100;
    remain[3] = 100;
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    check("ar_grants", 64'(gseq.size()), 64'(1));
    if (gseq.size() > 0) check("ar_restart_id", 64'(gseq[0]), 64'(0));

    // random traffic and back-pressure
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) remain[i] = 1000;
      step(N'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
